// File: rtl/spi_cmd_regs.sv
// SPI command decoder and register file.
// Decodes a byte-oriented command protocol framed by chip-select
// (rx_start/rx_end) into version reads, register writes, single reads
// and wrapping burst reads. Transmit bytes go out over a req/ack handshake.
module spi_cmd_regs #(
  parameter int                        BUS_DATA_WIDTH = 8,
  parameter int                        ADDR_WIDTH     = 4,
  parameter int                        NUM_REGS       = 16,
  parameter logic [BUS_DATA_WIDTH-1:0] FPGA_VERSION   = 8'h10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [BUS_DATA_WIDTH-1:0]          rx_data,
  input  logic                               rx_valid,
  input  logic                               rx_start,
  input  logic                               rx_end,
  input  logic                               tx_ack,
  output logic [BUS_DATA_WIDTH-1:0]          tx_data,
  output logic                               tx_req,
  output logic [NUM_REGS*BUS_DATA_WIDTH-1:0] regs_out,
  output logic                               wr_strobe,
  output logic [ADDR_WIDTH-1:0]              wr_addr,
  output logic                               cmd_err
);

  localparam logic [BUS_DATA_WIDTH-1:0] CODE_READ_VERSION = BUS_DATA_WIDTH'(1);
  localparam logic [BUS_DATA_WIDTH-1:0] CODE_WRITE_REG    = BUS_DATA_WIDTH'(2);
  localparam logic [BUS_DATA_WIDTH-1:0] CODE_READ_REG     = BUS_DATA_WIDTH'(3);
  localparam logic [BUS_DATA_WIDTH-1:0] CODE_BURST_READ   = BUS_DATA_WIDTH'(4);
  // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]       NUM_REGS_W        = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0]     LAST_ADDR         = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, TX, DRAIN} state_t;
  typedef enum logic [1:0] {OP_READ_VERSION, OP_WRITE_REG, OP_READ_REG, OP_BURST_READ} op_t;

  state_t                    state, state_nx;
  op_t                       op, op_nx;
  logic [ADDR_WIDTH-1:0]     addr, addr_nx;
  logic [BUS_DATA_WIDTH-1:0] tx_data_nx;
  logic                      tx_req_nx;
  logic                      wr_strobe_nx;
  logic [ADDR_WIDTH-1:0]     wr_addr_nx;
  logic                      cmd_err_nx;
  logic                      reg_we;
  logic [BUS_DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0]     rx_addr;

  assign rx_addr = rx_data[ADDR_WIDTH-1:0];

  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NUM_REGS_W);
  endfunction

  // Burst addresses wrap at the last implemented register, so an
  // out-of-range start address also resumes at 0.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a >= LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  // Flatten the register file onto the parallel output bus.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_out
    assign regs_out[i*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = regs[i];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and next-output decode; frame end beats frame start beats data.
  always_comb begin
    state_nx     = state;
    op_nx        = op;
    addr_nx      = addr;
    tx_data_nx   = tx_data;
    tx_req_nx    = tx_req;
    wr_strobe_nx = 1'b0;
    wr_addr_nx   = wr_addr;
    cmd_err_nx   = 1'b0;
    reg_we       = 1'b0;
    if (rx_end) begin
      state_nx  = IDLE;
      tx_req_nx = 1'b0;
    end else if (rx_start) begin
      state_nx  = CMD;
      tx_req_nx = 1'b0;
    end else begin
      case (state)
        CMD: if (rx_valid) begin
          if (rx_data == CODE_READ_VERSION) begin
            op_nx      = OP_READ_VERSION;
            state_nx   = TX;
            tx_data_nx = FPGA_VERSION;
            tx_req_nx  = 1'b1;
          end else if (rx_data == CODE_WRITE_REG) begin
            op_nx    = OP_WRITE_REG;
            state_nx = ADDR;
          end else if (rx_data == CODE_READ_REG) begin
            op_nx    = OP_READ_REG;
            state_nx = ADDR;
          end else if (rx_data == CODE_BURST_READ) begin
            op_nx    = OP_BURST_READ;
            state_nx = ADDR;
          end else begin
            state_nx   = DRAIN;
            cmd_err_nx = 1'b1;
          end
        end
        ADDR: if (rx_valid) begin
          addr_nx    = rx_addr;
          cmd_err_nx = !addr_ok(rx_addr);
          if (op == OP_WRITE_REG) begin
            state_nx = WDATA;
          end else begin
            state_nx   = TX;
            tx_data_nx = addr_ok(rx_addr) ? regs[rx_addr] : '0;
            tx_req_nx  = 1'b1;
          end
        end
        WDATA: if (rx_valid) begin
          state_nx = DRAIN;
          if (addr_ok(addr)) begin
            reg_we       = 1'b1;
            wr_strobe_nx = 1'b1;
            wr_addr_nx   = addr;
          end
        end
        TX: begin
          if (tx_req && tx_ack) begin
            tx_req_nx = 1'b0;
            if (op == OP_BURST_READ) begin
              addr_nx    = next_addr(addr);
              tx_data_nx = regs[next_addr(addr)];
            end else begin
              state_nx = DRAIN;
            end
          end else if (!tx_req && op == OP_BURST_READ) begin
            tx_req_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control, handshake and command-context registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op        <= OP_READ_VERSION;
      addr      <= '0;
      tx_data   <= '0;
      tx_req    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      cmd_err   <= 1'b0;
    end else begin
      op        <= op_nx;
      addr      <= addr_nx;
      tx_data   <= tx_data_nx;
      tx_req    <= tx_req_nx;
      wr_strobe <= wr_strobe_nx;
      wr_addr   <= wr_addr_nx;
      cmd_err   <= cmd_err_nx;
    end
  end

  // Register file: cleared by reset, written only by WRITE_REG.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[addr] <= rx_data;
    end
  end

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Directed bench for spi_cmd_regs: a default instance and a NUM_REGS=10
// instance share one stimulus stream; each check names the instance it covers.
module tb_spi_cmd_regs;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_start = 1'b0;
  logic         rx_end = 1'b0;
  logic         tx_ack = 1'b0;

  logic [7:0]   tx_data, tx_data_b;
  logic         tx_req, tx_req_b;
  logic [127:0] regs_out;
  logic [79:0]  regs_out_b;
  logic         wr_strobe, wr_strobe_b;
  logic [3:0]   wr_addr, wr_addr_b;
  logic         cmd_err, cmd_err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_cmd_regs dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_start(rx_start), .rx_end(rx_end), .tx_ack(tx_ack),
    .tx_data(tx_data), .tx_req(tx_req), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .cmd_err(cmd_err)
  );

  spi_cmd_regs #(.NUM_REGS(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_start(rx_start), .rx_end(rx_end), .tx_ack(tx_ack),
    .tx_data(tx_data_b), .tx_req(tx_req_b), .regs_out(regs_out_b),
    .wr_strobe(wr_strobe_b), .wr_addr(wr_addr_b), .cmd_err(cmd_err_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All drive tasks begin and end on a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic frame_start();
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
  endtask

  task automatic frame_end();
    rx_end = 1'b1;
    @(negedge clk);
    rx_end = 1'b0;
  endtask

  task automatic ack();
    tx_ack = 1'b1;
    @(negedge clk);
    tx_ack = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    frame_start();
    send_byte(8'h02);
    send_byte(a);
    send_byte(d);
    frame_end();
  endtask

  initial begin
    // Reset
    step();
    step();
    chk("rst_tx_req",    128'(tx_req),    128'(0));
    chk("rst_tx_data",   128'(tx_data),   128'(0));
    chk("rst_wr_strobe", 128'(wr_strobe), 128'(0));
    chk("rst_wr_addr",   128'(wr_addr),   128'(0));
    chk("rst_cmd_err",   128'(cmd_err),   128'(0));
    chk("rst_regs",      regs_out,        128'(0));
    rst_n = 1'b1;
    step();

    // READ_VERSION with handshake hold
    frame_start();
    chk("ver_req_before", 128'(tx_req), 128'(0));
    send_byte(8'h01);
    chk("ver_req_rise", 128'(tx_req),  128'(1));
    chk("ver_data",     128'(tx_data), 128'(8'h10));
    step();
    step();
    chk("ver_req_hold",  128'(tx_req),  128'(1));
    chk("ver_data_hold", 128'(tx_data), 128'(8'h10));
    ack();
    chk("ver_req_drop", 128'(tx_req), 128'(0));
    step();
    chk("ver_req_drain", 128'(tx_req), 128'(0));
    frame_end();

    // WRITE_REG 5 = A5, then READ_REG 5
    frame_start();
    send_byte(8'h02);
    send_byte(8'h05);
    chk("wr_no_err", 128'(cmd_err), 128'(0));
    send_byte(8'hA5);
    chk("wr_strobe",  128'(wr_strobe),       128'(1));
    chk("wr_addr",    128'(wr_addr),         128'(5));
    chk("wr_reg5",    128'(regs_out[47:40]), 128'(8'hA5));
    step();
    chk("wr_strobe_pulse", 128'(wr_strobe), 128'(0));
    frame_end();
    frame_start();
    send_byte(8'h03);
    send_byte(8'h05);
    chk("rd_req",  128'(tx_req),  128'(1));
    chk("rd_data", 128'(tx_data), 128'(8'hA5));
    ack();
    frame_end();

    // BURST_READ from 14 wrapping to 0
    write_reg(8'd14, 8'h11);
    write_reg(8'd15, 8'h22);
    write_reg(8'd0,  8'h33);
    frame_start();
    send_byte(8'h04);
    send_byte(8'h0E);
    chk("burst_req0",  128'(tx_req),  128'(1));
    chk("burst_data0", 128'(tx_data), 128'(8'h11));
    ack();
    chk("burst_gap0", 128'(tx_req), 128'(0));
    step();
    chk("burst_req1",  128'(tx_req),  128'(1));
    chk("burst_data1", 128'(tx_data), 128'(8'h22));
    ack();
    chk("burst_gap1", 128'(tx_req), 128'(0));
    step();
    chk("burst_req2",  128'(tx_req),  128'(1));
    chk("burst_data2", 128'(tx_data), 128'(8'h33));
    ack();
    frame_end();
    chk("burst_end_req", 128'(tx_req), 128'(0));

    // Unknown command, drain, restart mid-drain
    frame_start();
    send_byte(8'h7F);
    chk("bad_cmd_err", 128'(cmd_err), 128'(1));
    step();
    chk("bad_cmd_pulse", 128'(cmd_err), 128'(0));
    send_byte(8'h01);
    chk("drain_ign_req", 128'(tx_req), 128'(0));
    send_byte(8'h03);
    chk("drain_ign_req2", 128'(tx_req), 128'(0));
    frame_start();
    send_byte(8'h03);
    send_byte(8'h05);
    chk("restart_req",  128'(tx_req),  128'(1));
    chk("restart_data", 128'(tx_data), 128'(8'hA5));
    ack();
    frame_end();

    // NUM_REGS=10 instance: out-of-range write and read at address 12
    frame_start();
    send_byte(8'h02);
    send_byte(8'h0C);
    chk("b_wr_oor_err", 128'(cmd_err_b), 128'(1));
    send_byte(8'h77);
    chk("b_wr_oor_strobe", 128'(wr_strobe_b), 128'(0));
    chk("b_regs_unchanged", 128'(regs_out_b), (128'hA5 << 40) | 128'h33);
    frame_end();
    frame_start();
    send_byte(8'h03);
    send_byte(8'h0C);
    chk("b_rd_oor_err",  128'(cmd_err_b), 128'(1));
    chk("b_rd_oor_req",  128'(tx_req_b),  128'(1));
    chk("b_rd_oor_data", 128'(tx_data_b), 128'(0));
    ack();
    frame_end();

    // rx_end coincident with the data byte discards the write
    frame_start();
    send_byte(8'h02);
    send_byte(8'h03);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    rx_end   = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_end   = 1'b0;
    chk("end_wr_strobe", 128'(wr_strobe),       128'(0));
    chk("end_wr_reg3",   128'(regs_out[31:24]), 128'(0));
    send_byte(8'h5A);
    chk("idle_ign_reg3", 128'(regs_out[31:24]), 128'(0));

    // Reset while tx_req is high
    frame_start();
    send_byte(8'h01);
    chk("pre_rst_req", 128'(tx_req), 128'(1));
    rst_n = 1'b0;
    step();
    chk("mid_rst_req",   128'(tx_req),    128'(0));
    chk("mid_rst_data",  128'(tx_data),   128'(0));
    chk("mid_rst_regs",  regs_out,        128'(0));
    chk("mid_rst_waddr", 128'(wr_addr),   128'(0));
    chk("mid_rst_err",   128'(cmd_err),   128'(0));
    rst_n = 1'b1;
    step();
    send_byte(8'h01);
    chk("post_rst_ign", 128'(tx_req), 128'(0));
    ack();
    chk("stray_ack_req", 128'(tx_req), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_cmd_regs.md
SPI_CMD_REGS -- requirements
Module: spi_cmd_regs

Interface
REQ-001 The module SHALL have parameter BUS_DATA_WIDTH, default 8, giving the SPI byte/word width and the register width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 4, giving the register address width.
REQ-003 The module SHALL have parameter NUM_REGS, default 16, giving the implemented register count; legal range is 1..2**ADDR_WIDTH.
REQ-004 The module SHALL have parameter FPGA_VERSION, default 8'h10, giving the value returned by the version command.
REQ-005 The clk port SHALL be an input, 1 bit wide, and is the single clock; all logic is on its rising edge.
REQ-006 The rst_n port SHALL be an input, 1 bit wide; reset is synchronous and active-low.
REQ-007 The rx_data port SHALL be an input, BUS_DATA_WIDTH bits wide, carrying the received byte; it is qualified by rx_valid.
REQ-008 The rx_valid port SHALL be an input, 1 bit wide; it pulses for one cycle per received byte.
REQ-009 The rx_start port SHALL be an input, 1 bit wide; it pulses for one cycle when chip-select is asserted (frame start).
REQ-010 The rx_end port SHALL be an input, 1 bit wide; it pulses for one cycle when chip-select is deasserted (frame end).
REQ-011 The tx_ack port SHALL be an input, 1 bit wide; it is the transmitter's acceptance of tx_data.
REQ-012 The tx_data port SHALL be an output, BUS_DATA_WIDTH bits wide, carrying the byte to shift out.
REQ-013 The tx_req port SHALL be an output, 1 bit wide, requesting transmission of tx_data.
REQ-014 The regs_out port SHALL be an output, NUM_REGS*BUS_DATA_WIDTH bits wide; register i occupies bits [i*W +: W].
REQ-015 The wr_strobe port SHALL be an output, 1 bit wide, pulsing for one cycle when a register is written.
REQ-016 The wr_addr port SHALL be an output, ADDR_WIDTH bits wide, giving the address of the last write; it is valid with wr_strobe.
REQ-017 The cmd_err port SHALL be an output, 1 bit wide, pulsing for one cycle on an unknown command or an out-of-range address.

Function
REQ-018 The module SHALL implement the command set: 0x01 READ_VERSION; 0x02 WRITE_REG (addr byte, data byte); 0x03 READ_REG (addr byte); 0x04 BURST_READ (start addr byte).
REQ-019 The FSM SHALL have states IDLE, CMD, ADDR, WDATA, TX, DRAIN.
REQ-020 The FSM SHALL apply event priority per cycle as follows: rst_n low > rx_end > rx_start > rx_valid.
REQ-021 On rx_end in any state, the FSM SHALL go to IDLE, drive tx_req low the next cycle, and discard any coincident rx_valid byte.
REQ-022 On rx_start in any state (including mid-frame), the FSM SHALL go to CMD and clear tx_req.
REQ-023 In CMD, on rx_valid, the FSM SHALL decode rx_data: 0x01 -> TX with tx_data=FPGA_VERSION; 0x02/0x03/0x04 -> ADDR; any other value -> DRAIN with a cmd_err pulse.
REQ-024 In ADDR, on rx_valid, the FSM SHALL latch the address (low ADDR_WIDTH bits); WRITE_REG -> WDATA; READ_REG/BURST_READ -> TX with tx_data=reg[addr].
REQ-025 If the address is >= NUM_REGS, the FSM SHALL pulse cmd_err; a read SHALL return tx_data=0 and a write SHALL be ignored with no wr_strobe.
REQ-026 In WDATA, on rx_valid, the module SHALL update reg[addr]<=rx_data and assert wr_strobe and wr_addr on the following cycle, then go to DRAIN.
REQ-027 Latency: tx_req SHALL rise exactly one cycle after the rx_valid that completes the command or address.
REQ-028 Handshake: tx_req and tx_data SHALL remain stable until tx_ack is sampled high; tx_req SHALL be low on the following cycle.
REQ-029 tx_ack received while tx_req is low SHALL be ignored.
REQ-030 In TX, after ack: READ_VERSION/READ_REG SHALL go to DRAIN.
REQ-031 In TX, after ack, BURST_READ SHALL increment the address, load the next register, and re-assert tx_req on the cycle after tx_req drops, repeating until rx_end.
REQ-032 BURST_READ address SHALL wrap from NUM_REGS-1 to 0, never reaching out-of-range addresses after the start address.
REQ-033 In DRAIN, all rx_valid bytes SHALL be ignored until rx_end or rx_start.
REQ-034 In IDLE, rx_valid SHALL be ignored (no frame open).
REQ-035 Register contents SHALL persist across frames and are changed only by WRITE_REG or reset.

Reset
REQ-036 While rst_n is low at a clk edge, the module SHALL clear all registers, tx_data, tx_req, wr_strobe, wr_addr, and cmd_err to 0, and set the FSM to IDLE.
REQ-037 Reset asserted mid-frame or mid-handshake SHALL abort immediately; the module SHALL ignore bytes until the next rx_start.

Verification
REQ-038 rx_start, 0x01 -> tx_req high 1 cycle later with tx_data=0x10; held until tx_ack; low the next cycle; rx_end -> IDLE.
REQ-039 rx_start, 0x02, 0x05, 0xA5, rx_end -> wr_strobe pulse with wr_addr=5; regs_out[47:40]=0xA5; then 0x03, 0x05 frame -> tx_data=0xA5.
REQ-040 Registers 14=0x11, 15=0x22, 0=0x33; BURST_READ from 14 with three acks -> tx_data sequence 0x11, 0x22, 0x33 (wrap verified).
REQ-041 Command 0x7F -> cmd_err pulse; following bytes ignored; no tx_req; rx_start mid-DRAIN restarts decoding correctly.
REQ-042 NUM_REGS=10, WRITE_REG addr 12 -> cmd_err pulse, no wr_strobe, regs unchanged; READ_REG 12 -> tx_data=0.
REQ-043 rx_end coincident with the WDATA rx_valid -> no write; rst_n low while tx_req high -> all outputs 0 on the next cycle.
